// File: rtl/quad_encoder_counter.sv
// ============================================================================
// Module  : quad_encoder_counter
// Brief   : Quadrature encoder front end with sync, debounce, decode and a
//           bounded 16-bit position count. Define QUAD_ENC_WRAP_EN to make
//           the count wrap at its bounds instead of saturating.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_encoder_counter #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MIN_VAL         = 0,
    parameter int unsigned MAX_VAL         = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    input  logic             rd_strobe,
    output logic [WIDTH-1:0] count,
    output logic             changed,
    output logic             err
);

    localparam logic [WIDTH-1:0] C_MIN = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [7:0]       C_DEB = 8'(DEBOUNCE_CYCLES);

    logic             r_aMeta, r_bMeta, r_aSync, r_bSync;
    logic [1:0]       r_prevSyncAb, r_accAb, r_accPrevAb;
    logic [7:0]       r_dbCnt;
    logic [WIDTH-1:0] r_count;
    logic             r_changed, r_err;

    logic [1:0]       w_syncAb;
    logic [7:0]       w_dbRun, w_dbNext;
    logic             w_accept;
    logic             w_up, w_down, w_illegal;
    logic [WIDTH-1:0] w_nextCount;
    logic             w_countChange;

    assign w_syncAb = {r_aSync, r_bSync};

    // A differing level must stay put for DEBOUNCE_CYCLES samples to be accepted.
    always_comb begin
        w_dbRun  = (w_syncAb != r_prevSyncAb) ? 8'd1 : (r_dbCnt + 8'd1);
        w_dbNext = '0;
        w_accept = 1'b0;
        if (w_syncAb != r_accAb) begin
            if (w_dbRun == C_DEB) begin
                w_accept = 1'b1;
            end else begin
                w_dbNext = w_dbRun;
            end
        end
    end

    // The accepted pair differs from its one-cycle-old copy only right after acceptance.
    always_comb begin
        w_up      = 1'b0;
        w_down    = 1'b0;
        w_illegal = 1'b0;
        case ({r_accPrevAb, r_accAb})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_up      = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: w_down    = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_nextCount   = r_count;
        w_countChange = 1'b0;
        if (w_up) begin
            if (r_count >= C_MAX) begin
`ifdef QUAD_ENC_WRAP_EN
                w_nextCount   = C_MIN;
                w_countChange = 1'b1;
`endif
            end else begin
                w_nextCount   = r_count + C_ONE;
                w_countChange = 1'b1;
            end
        end else if (w_down) begin
            if (r_count <= C_MIN) begin
`ifdef QUAD_ENC_WRAP_EN
                w_nextCount   = C_MAX;
                w_countChange = 1'b1;
`endif
            end else begin
                w_nextCount   = r_count - C_ONE;
                w_countChange = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aMeta      <= 1'b0;
            r_bMeta      <= 1'b0;
            r_aSync      <= 1'b0;
            r_bSync      <= 1'b0;
            r_prevSyncAb <= 2'b00;
            r_dbCnt      <= '0;
            r_accAb      <= 2'b00;
            r_accPrevAb  <= 2'b00;
            r_count      <= C_MIN;
            r_changed    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_aMeta      <= enc_a;
            r_bMeta      <= enc_b;
            r_aSync      <= r_aMeta;
            r_bSync      <= r_bMeta;
            r_prevSyncAb <= w_syncAb;
            r_dbCnt      <= w_dbNext;
            if (w_accept) begin
                r_accAb <= w_syncAb;
            end
            r_accPrevAb <= r_accAb;
            if (w_illegal) begin
                r_err <= 1'b1;
            end
            // clr beats a step; a real change beats a read clearing the flag.
            if (clr) begin
                r_count   <= C_MIN;
                r_changed <= 1'b0;
            end else if (w_countChange) begin
                r_count   <= w_nextCount;
                r_changed <= 1'b1;
            end else if (rd_strobe) begin
                r_changed <= 1'b0;
            end
        end
    end

    assign count   = r_count;
    assign changed = r_changed;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_encoder_counter.sv
// ============================================================================
// Module  : tb_quad_encoder_counter
// Brief   : Directed scoreboard bench for quad_encoder_counter (default params).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_encoder_counter;

    localparam int unsigned MINV = 0;
    localparam int unsigned MAXV = 255;

    logic        clk = 1'b0;
    logic        rst_n, enc_a, enc_b, clr, rd_strobe;
    logic [15:0] count;
    logic        changed, err;

    always #5 clk = ~clk;

    quad_encoder_counter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .clr       (clr),
        .rd_strobe (rd_strobe),
        .count     (count),
        .changed   (changed),
        .err       (err)
    );

    typedef struct {
        string       tag;
        logic [15:0] cnt;
        logic        chg;
        logic        er;
    } exp_t;

    exp_t        sbq[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned mCount      = MINV;
    bit          mChanged    = 1'b0;
    bit          mErr        = 1'b0;
    logic [1:0]  ab          = 2'b00;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] v);
        ab    = v;
        enc_a = v[1];
        enc_b = v[0];
    endtask

    function automatic logic [1:0] nextUp(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] nextDn(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Reference position model: saturate at bounds, or wrap when enabled.
    function automatic void modelStep(input bit up);
        if (up) begin
            if (mCount == MAXV) begin
`ifdef QUAD_ENC_WRAP_EN
                mCount   = MINV;
                mChanged = 1'b1;
`endif
            end else begin
                mCount   = mCount + 1;
                mChanged = 1'b1;
            end
        end else begin
            if (mCount == MINV) begin
`ifdef QUAD_ENC_WRAP_EN
                mCount   = MAXV;
                mChanged = 1'b1;
`endif
            end else begin
                mCount   = mCount - 1;
                mChanged = 1'b1;
            end
        end
    endfunction

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag;
        e.cnt = 16'(mCount);
        e.chg = mChanged;
        e.er  = mErr;
        sbq.push_back(e);
    endtask

    task automatic checkOut();
        exp_t e;
        e = sbq.pop_front();
        vectors++;
        assert (count === e.cnt) else begin
            miscompares++;
            $error("FAIL %s count observed=%0d expected=%0d", e.tag, count, e.cnt);
        end
        vectors++;
        assert (changed === e.chg) else begin
            miscompares++;
            $error("FAIL %s changed observed=%b expected=%b", e.tag, changed, e.chg);
        end
        vectors++;
        assert (err === e.er) else begin
            miscompares++;
            $error("FAIL %s err observed=%b expected=%b", e.tag, err, e.er);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; rd_strobe = 1'b0;
        drive(2'b00);

        push("reset");
        tick(3);
        checkOut();
        rst_n = 1'b1;
        push("idle50");
        tick(50);
        checkOut();

        // Clean up-step: nothing after 6 clocks, count moves on the 7th.
        drive(2'b01);
        push("latency6");
        tick(6);
        checkOut();
        modelStep(1'b1);
        push("latency7");
        tick(1);
        checkOut();
        tick(3);
        rd_strobe = 1'b1;
        mChanged  = 1'b0;
        push("read_clear");
        tick(1);
        rd_strobe = 1'b0;
        checkOut();

        // A held high for 3 samples is rejected.
        drive(2'b11);
        push("glitch3");
        tick(3);
        drive(2'b01);
        tick(12);
        checkOut();

        // A held high for 4 samples is accepted as up, then the fall as down.
        drive(2'b11);
        modelStep(1'b1);
        push("pulse4_up");
        tick(4);
        drive(2'b01);
        tick(3);
        checkOut();
        modelStep(1'b0);
        push("pulse4_down");
        tick(10);
        checkOut();

        clr    = 1'b1;
        mCount = MINV; mChanged = 1'b0;
        push("clr");
        tick(1);
        clr = 1'b0;
        checkOut();

        for (int i = 0; i < 255; i++) begin
            drive(nextUp(ab));
            modelStep(1'b1);
            tick(6);
        end
        push("fwd255");
        tick(4);
        checkOut();
        rd_strobe = 1'b1;
        mChanged  = 1'b0;
        tick(1);
        rd_strobe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(nextUp(ab));
            modelStep(1'b1);
            tick(6);
        end
        push("fwd260");
        tick(4);
        checkOut();

        clr    = 1'b1;
        mCount = MINV; mChanged = 1'b0;
        tick(1);
        clr = 1'b0;
        drive(nextDn(ab));
        modelStep(1'b0);
        push("down_at_min");
        tick(8);
        checkOut();

        drive(ab ^ 2'b11);
        mErr = 1'b1;
        push("illegal");
        tick(8);
        checkOut();

        drive(nextUp(ab));
        modelStep(1'b1);
        push("up_after_err");
        tick(8);
        checkOut();

        // clr lands in the same cycle as the decoded step.
        drive(nextUp(ab));
        tick(6);
        clr    = 1'b1;
        mCount = MINV; mChanged = 1'b0;
        push("clr_vs_step");
        tick(1);
        clr = 1'b0;
        checkOut();

        // rd_strobe lands in the same cycle as the decoded step.
        drive(nextUp(ab));
        modelStep(1'b1);
        tick(6);
        rd_strobe = 1'b1;
        push("rd_vs_step");
        tick(1);
        rd_strobe = 1'b0;
        checkOut();

        drive(nextUp(ab));
        tick(3);
        rst_n  = 1'b0;
        mCount = MINV; mChanged = 1'b0; mErr = 1'b0;
        push("mid_reset");
        tick(1);
        rst_n = 1'b1;
        checkOut();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
